// File: rtl/alureg_pkg.sv
// Shared opcode, ALU-op and sequencer state encodings for the alureg command sequencer.
package alureg_pkg;

    localparam logic [1:0] OPC_NOP = 2'b00;
    localparam logic [1:0] OPC_LDI = 2'b01;
    localparam logic [1:0] OPC_ALU = 2'b10;
    localparam logic [1:0] OPC_RPT = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StLoop = 2'b10,
        StDone = 2'b11
    } state_e;

endpackage

// File: rtl/alureg_seq.sv
// Command sequencer for the alureg register-file/ALU datapath: accepts one command at a time
// and drives the datapath controls combinationally from state plus the latched command.
module alureg_seq
    import alureg_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_opc,
    input  logic [1:0]    cmd_alu_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [DW-1:0] cmd_imm,
    input  logic [CW-1:0] cmd_cnt,
    input  logic          dp_cout,
    output logic [1:0]    dp_op,
    output logic [AW-1:0] dp_rd_addr_a,
    output logic [AW-1:0] dp_rd_addr_b,
    output logic [AW-1:0] dp_wr_addr,
    output logic          dp_wr,
    output logic          dp_sel,
    output logic [DW-1:0] dp_d_in,
    output logic          busy,
    output logic          done,
    output logic          done_cout
);

    state_e        state_q, state_d;
    logic [1:0]    opc_q, alu_op_q;
    logic [AW-1:0] rd_q, ra_q, rb_q;
    logic [DW-1:0] imm_q;
    logic [CW-1:0] rpt_cnt_q;
    logic [CW-1:0] loop_cnt_q, loop_cnt_d;
    logic          done_cout_q, done_cout_d;
    logic          wr_raw;
    logic          accept;

    assign accept = cmd_valid & cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            opc_q       <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            imm_q       <= '0;
            rpt_cnt_q   <= '0;
            loop_cnt_q  <= '0;
            done_cout_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            loop_cnt_q  <= loop_cnt_d;
            done_cout_q <= done_cout_d;
            if (accept) begin
                opc_q     <= cmd_opc;
                alu_op_q  <= cmd_alu_op;
                rd_q      <= cmd_rd;
                ra_q      <= cmd_ra;
                rb_q      <= cmd_rb;
                imm_q     <= cmd_imm;
                rpt_cnt_q <= cmd_cnt;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        loop_cnt_d   = loop_cnt_q;
        done_cout_d  = done_cout_q;
        cmd_ready    = 1'b0;
        wr_raw       = 1'b0;
        dp_sel       = 1'b0;
        dp_op        = '0;
        dp_rd_addr_a = '0;
        dp_rd_addr_b = '0;
        dp_wr_addr   = '0;
        dp_d_in      = '0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = StExec;
            end
            StExec: begin
                state_d = StDone;
                unique case (opc_q)
                    OPC_NOP: ;
                    OPC_LDI: begin
                        wr_raw     = 1'b1;
                        dp_wr_addr = rd_q;
                        dp_d_in    = imm_q;
                    end
                    OPC_ALU: begin
                        wr_raw       = 1'b1;
                        dp_sel       = 1'b1;
                        dp_rd_addr_a = ra_q;
                        dp_rd_addr_b = rb_q;
                        dp_wr_addr   = rd_q;
                        dp_op        = alu_op_q;
                        done_cout_d  = dp_cout;
                    end
                    OPC_RPT: begin
                        loop_cnt_d = rpt_cnt_q;
                        if (rpt_cnt_q != '0) state_d = StLoop;
                    end
                endcase
            end
            StLoop: begin
                // Accumulate into rd: each iteration reads back the previous cycle's write.
                wr_raw       = 1'b1;
                dp_sel       = 1'b1;
                dp_rd_addr_a = rd_q;
                dp_rd_addr_b = rb_q;
                dp_wr_addr   = rd_q;
                dp_op        = alu_op_q;
                done_cout_d  = dp_cout;
                loop_cnt_d   = loop_cnt_q - CW'(1);
                if (loop_cnt_q == CW'(1)) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A reset landing mid-command must not let the in-flight write reach the register file.
    assign dp_wr     = wr_raw & ~reset;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign done_cout = done_cout_q;

endmodule

// File: tb/tb_alureg_seq.sv
// Directed bench for alureg_seq driving a small behavioural register-file/ALU datapath.
module tb_alureg_seq;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_opc = '0;
    logic [1:0]    cmd_alu_op = '0;
    logic [AW-1:0] cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
    logic [DW-1:0] cmd_imm = '0;
    logic [CW-1:0] cmd_cnt = '0;
    logic          dp_cout;
    logic [1:0]    dp_op;
    logic [AW-1:0] dp_rd_addr_a, dp_rd_addr_b, dp_wr_addr;
    logic          dp_wr, dp_sel;
    logic [DW-1:0] dp_d_in;
    logic          busy, done, done_cout;

    always #5 clk = ~clk;

    alureg_seq #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opc     (cmd_opc),
        .cmd_alu_op  (cmd_alu_op),
        .cmd_rd      (cmd_rd),
        .cmd_ra      (cmd_ra),
        .cmd_rb      (cmd_rb),
        .cmd_imm     (cmd_imm),
        .cmd_cnt     (cmd_cnt),
        .dp_cout     (dp_cout),
        .dp_op       (dp_op),
        .dp_rd_addr_a(dp_rd_addr_a),
        .dp_rd_addr_b(dp_rd_addr_b),
        .dp_wr_addr  (dp_wr_addr),
        .dp_wr       (dp_wr),
        .dp_sel      (dp_sel),
        .dp_d_in     (dp_d_in),
        .busy        (busy),
        .done        (done),
        .done_cout   (done_cout)
    );

    // Behavioural datapath: 8 x 16 register file, synchronous write, combinational read + ALU.
    logic [DW-1:0] regs [8];
    logic [DW-1:0] ra_v, rb_v, alu_y;
    logic          alu_c;
    int            wr_edges = 0;
    int            hs_edges = 0;

    assign ra_v    = regs[dp_rd_addr_a];
    assign rb_v    = regs[dp_rd_addr_b];
    assign dp_cout = alu_c;

    always_comb begin
        alu_c = 1'b0;
        alu_y = '0;
        case (dp_op)
            2'b00:   {alu_c, alu_y} = {1'b0, ra_v} + {1'b0, rb_v};
            2'b01:   {alu_c, alu_y} = {1'b0, ra_v} - {1'b0, rb_v};
            2'b10:   alu_y = ra_v & rb_v;
            default: alu_y = ra_v | rb_v;
        endcase
    end

    always @(posedge clk) begin
        if (dp_wr) begin
            regs[dp_wr_addr] <= dp_sel ? alu_y : dp_d_in;
            wr_edges <= wr_edges + 1;
        end
        if (cmd_valid && cmd_ready) hs_edges <= hs_edges + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int            done_cyc, wr_cnt, first_wr, last_wr;
    logic          ready_bad, ready_after;
    logic          c1_wr, c1_sel;
    logic [AW-1:0] c1_ra, c1_rb, c1_waddr;
    logic [DW-1:0] c1_din;

    // Issue one command from a negedge, then watch cycles T+1.. until done; returns at T+done+1.
    task automatic run_cmd(input logic [1:0] opc, input logic [1:0] op, input logic [2:0] rd,
                           input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] imm,
                           input logic [3:0] cnt, input bit hold);
        done_cyc  = 0;
        wr_cnt    = 0;
        first_wr  = 0;
        last_wr   = 0;
        ready_bad = 1'b0;
        cmd_opc = opc; cmd_alu_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
        cmd_imm = imm; cmd_cnt = cnt;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 1) begin
                c1_wr = dp_wr; c1_sel = dp_sel; c1_ra = dp_rd_addr_a; c1_rb = dp_rd_addr_b;
                c1_waddr = dp_wr_addr; c1_din = dp_d_in;
            end
            if (dp_wr) begin
                wr_cnt++;
                if (first_wr == 0) first_wr = k;
                last_wr = k;
            end
            if (cmd_ready) ready_bad = 1'b1;
            if (done) begin
                done_cyc = k;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        ready_after = cmd_ready;
    endtask

    initial begin
        int   hs0, wr0;
        logic saw_done;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_cout", done_cout, 0);
        check("rst_dp_wr", dp_wr, 0);

        run_cmd(2'b01, 2'b00, 3'd3, 3'd0, 3'd0, 16'h1234, 4'd0, 1'b0);
        check("ldi_c1_wr", c1_wr, 1);
        check("ldi_c1_sel", c1_sel, 0);
        check("ldi_c1_waddr", c1_waddr, 3);
        check("ldi_c1_din", c1_din, 16'h1234);
        check("ldi_done_cyc", done_cyc, 2);
        check("ldi_wr_cnt", wr_cnt, 1);
        check("ldi_ready_after", ready_after, 1);
        check("ldi_r3", regs[3], 16'h1234);

        run_cmd(2'b01, 2'b00, 3'd1, 3'd0, 3'd0, 16'hFFFF, 4'd0, 1'b0);
        run_cmd(2'b01, 2'b00, 3'd2, 3'd0, 3'd0, 16'h0001, 4'd0, 1'b0);
        run_cmd(2'b10, 2'b00, 3'd4, 3'd1, 3'd2, 16'h0000, 4'd0, 1'b0);
        check("alu_c1_sel", c1_sel, 1);
        check("alu_c1_ra", c1_ra, 1);
        check("alu_c1_rb", c1_rb, 2);
        check("alu_done_cyc", done_cyc, 2);
        check("alu_r4", regs[4], 16'h0000);
        check("alu_done_cout", done_cout, 1);

        run_cmd(2'b01, 2'b00, 3'd5, 3'd0, 3'd0, 16'h0003, 4'd0, 1'b0);
        run_cmd(2'b01, 2'b00, 3'd6, 3'd0, 3'd0, 16'h0002, 4'd0, 1'b0);
        run_cmd(2'b11, 2'b00, 3'd5, 3'd0, 3'd6, 16'h0000, 4'd4, 1'b0);
        check("rpt4_wr_cnt", wr_cnt, 4);
        check("rpt4_first_wr", first_wr, 2);
        check("rpt4_last_wr", last_wr, 5);
        check("rpt4_done_cyc", done_cyc, 6);
        check("rpt4_r5", regs[5], 16'h000B);
        check("rpt4_done_cout", done_cout, 0);
        check("rpt4_ready_busy", ready_bad, 0);

        run_cmd(2'b10, 2'b00, 3'd7, 3'd1, 3'd1, 16'h0000, 4'd0, 1'b0);
        check("alu2_r7", regs[7], 16'hFFFE);
        check("alu2_done_cout", done_cout, 1);
        hs0 = hs_edges;
        run_cmd(2'b11, 2'b00, 3'd5, 3'd0, 3'd6, 16'h0000, 4'd0, 1'b1);
        check("rpt0_wr_cnt", wr_cnt, 0);
        check("rpt0_done_cyc", done_cyc, 2);
        check("rpt0_done_cout", done_cout, 1);
        check("rpt0_ready_busy", ready_bad, 0);
        @(negedge clk);
        check("rpt0_idle_busy", busy, 0);
        check("rpt0_one_accept", hs_edges - hs0, 1);
        run_cmd(2'b01, 2'b00, 3'd0, 3'd0, 3'd0, 16'h00AA, 4'd0, 1'b0);
        check("ldi_keep_cout", done_cout, 1);

        wr0 = wr_edges;
        cmd_opc = 2'b11; cmd_alu_op = 2'b00; cmd_rd = 3'd5; cmd_rb = 3'd6; cmd_cnt = 4'd8;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_loop1_wr", dp_wr, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_loop2_wr", dp_wr, 0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", saw_done, 0);
        check("abort_one_write", wr_edges - wr0, 1);
        check("abort_r5", regs[5], 16'h000D);
        check("abort_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_done_cout", done_cout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alureg_seq.md
Name: alureg_seq

Overview:
Command sequencer that drives the register-file/ALU datapath (alureg) from a valid/ready command stream. It decodes one command at a time, then drives the datapath controls: read/write addresses, wr, sel, op and d_in. It supports immediate load, single ALU op and a counted repeat-accumulate loop. It reports completion with a one-cycle done pulse and the captured carry.

Parameters:
DW, 16, datapath data width (d_in / imm width)
AW, 3, register address width (8 registers)
CW, 4, repeat-count width (max 15 iterations)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept (high only in IDLE)
cmd_opc  in  2  00 NOP, 01 LDI, 10 ALU, 11 RPT
cmd_alu_op  in  2  ALU op forwarded to datapath (00 = ADD in team ALU)
cmd_rd  in  AW  destination register
cmd_ra  in  AW  source A (ALU only)
cmd_rb  in  AW  source B (ALU, RPT)
cmd_imm  in  DW  immediate (LDI only)
cmd_cnt  in  CW  iteration count (RPT only)
dp_cout  in  1  carry from datapath ALU
dp_op  out  2  to datapath op
dp_rd_addr_a  out  AW  to datapath rd_addr_a
dp_rd_addr_b  out  AW  to datapath rd_addr_b
dp_wr_addr  out  AW  to datapath wr_addr
dp_wr  out  1  to datapath wr
dp_sel  out  1  to datapath sel (1 = ALU result, 0 = d_in)
dp_d_in  out  DW  to datapath d_in
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
done_cout  out  1  carry of the last write cycle of the last command

Behaviour:
- Reset (sync): state = IDLE, latched command fields = 0, loop counter = 0, done = 0, done_cout = 0.
- While reset is high, dp_wr is forced to 0 combinationally.
- States: IDLE, EXEC, LOOP, DONE.
- IDLE: cmd_ready = 1. Handshake is cmd_valid & cmd_ready at a rising edge. On handshake, latch all cmd_* fields and go to EXEC.
- EXEC:
  - NOP: no write; go to DONE.
  - LDI: dp_wr = 1, dp_sel = 0, dp_wr_addr = rd, dp_d_in = imm; go to DONE.
  - ALU: dp_wr = 1, dp_sel = 1, dp_rd_addr_a = ra, dp_rd_addr_b = rb, dp_wr_addr = rd, dp_op = alu_op. Capture dp_cout into done_cout; go to DONE.
  - RPT: no write. Load counter = cnt. Go to DONE if cnt == 0, else to LOOP.
- LOOP: one iteration per cycle, with dp_rd_addr_a = rd, dp_rd_addr_b = rb, dp_wr_addr = rd, dp_op = alu_op, dp_wr = 1, dp_sel = 1.
  - Each cycle: capture dp_cout into done_cout and decrement the counter.
  - Go to DONE when counter == 1 at the edge.
  - The register file writes synchronously, so each iteration reads the previous result.
- DONE: done = 1 for exactly one cycle, cmd_ready = 0, then IDLE.
- cmd_valid asserted outside IDLE is ignored and not consumed.
- Outside write cycles: dp_wr = 0, dp_sel = 0, addresses/op/d_in = 0.
- All dp_* outputs are combinational from state plus latched fields; no extra pipeline register.
- Latency, with handshake at edge T:
  - LDI/ALU: write in cycle T+1, done in T+2, ready in T+3.
  - RPT cnt = N > 0: writes in T+2..T+N+1, done in T+N+2.
  - NOP or RPT cnt = 0: done in T+2.
- done_cout is unchanged by LDI, NOP and RPT cnt = 0.
- Reset mid-command aborts it: no further writes and no done pulse.

Decomposition:
- Package alureg_pkg holds:
  - opcode localparams: OPC_NOP, OPC_LDI, OPC_ALU, OPC_RPT
  - state enum encoding: IDLE, EXEC, LOOP, DONE
  - ALU op constants
- No sub-module: single FSM plus down-counter. The bench instantiates alureg_seq with alureg for end-to-end checks.

Test Plan:
1. Reset held 2 cycles, then released -> cmd_ready = 1, busy = 0, done = 0, done_cout = 0, dp_wr = 0.
2. LDI rd=3 imm=0x1234 -> next cycle dp_wr = 1, dp_sel = 0, dp_wr_addr = 3, dp_d_in = 0x1234; done the cycle after; r3 reads 0x1234.
3. LDI r1=0xFFFF, LDI r2=0x0001, then ALU ADD rd=4 ra=1 rb=2 -> r4 = 0x0000, done_cout = 1.
4. r5=0x0003, r6=0x0002, then RPT ADD rd=5 rb=6 cnt=4 -> dp_wr high in exactly 4 consecutive cycles; r5 = 0x000B; done at T+6.
5. RPT cnt=0 -> dp_wr never asserted, done at T+2. cmd_valid held high during EXEC/DONE -> only one command accepted.
6. RPT cnt=8, reset asserted during the 2nd LOOP cycle -> dp_wr = 0 that cycle; one write observed; no done pulse; IDLE with cmd_ready = 1 after reset.
